// File: rtl/lsu_stage.sv
// Load/store unit behind the ALU: one sized data-memory access per request over req/gnt/rvalid.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module lsu_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [3:0]            o_mem_be,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_d;
    logic                  w_capture;
    logic                  w_take_rdata;

    logic                  r_req_ready;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [3:0]            r_mem_be;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;

    logic [1:0]            w_size;
    logic                  w_f3_legal;
    logic                  w_misaligned;
    logic                  w_err;
    logic [1:0]            w_off;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Request decode: legality, lane offset, byte enables and lane-replicated store data
    always_comb begin
        w_size       = i_req_funct3[1:0];
        w_f3_legal   = i_req_we ? (!i_req_funct3[2] && (w_size != 2'b11))
                                : ((w_size != 2'b11) && !(i_req_funct3[2] && (w_size == SZ_WORD)));
        w_misaligned = ((w_size == SZ_HALF) && i_req_addr[0]) ||
                       ((w_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        w_err = !w_f3_legal || w_misaligned;
        w_off = i_req_addr[1:0];
`else
        w_err = !w_f3_legal;
        case (w_size)
            SZ_HALF: w_off = {i_req_addr[1], 1'b0};
            SZ_WORD: w_off = 2'b00;
            default: w_off = i_req_addr[1:0];
        endcase
`endif
        w_be    = 4'b1111;
        w_wdata = '0;
        if (i_req_we) begin
            case (w_size)
                SZ_BYTE: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = DATA_WIDTH'({4{i_req_wdata[7:0]}});
                end
                SZ_HALF: begin
                    w_be    = 4'b0011 << w_off;
                    w_wdata = DATA_WIDTH'({2{i_req_wdata[15:0]}});
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = i_req_wdata;
                end
            endcase
        end
    end

    // Pick the addressed lane(s) out of the read word and extend to full width
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [2:0] f3,
                                                      input logic [1:0] off,
                                                      input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] sh;
        sh = d >> {off, 3'b000};
        case (f3)
            3'b000:  extract = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            3'b100:  extract = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            3'b001:  extract = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            3'b101:  extract = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: extract = d;
        endcase
    endfunction

    // Next-state logic
    always_comb begin
        w_state_d    = r_state;
        w_capture    = 1'b0;
        w_take_rdata = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    w_capture = 1'b1;
                    w_state_d = w_err ? RESP : REQ;
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    if (r_mem_we) begin
                        w_state_d = RESP;
                    end else if (i_mem_rvalid) begin
                        w_take_rdata = 1'b1;
                        w_state_d    = RESP;
                    end else begin
                        w_state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    w_take_rdata = 1'b1;
                    w_state_d    = RESP;
                end
            end
            RESP:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // State, captured request and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
        end else begin
            r_state     <= w_state_d;
            r_req_ready <= (w_state_d == IDLE);
            r_mem_req   <= (w_state_d == REQ);
            r_rsp_valid <= (w_state_d == RESP);
            if (w_capture) begin
                r_mem_we    <= i_req_we;
                r_mem_addr  <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
                r_funct3    <= i_req_funct3;
                r_off       <= w_off;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= '0;
            end
            if (w_take_rdata) begin
                r_rsp_rdata <= extract(r_funct3, r_off, i_mem_rdata);
            end
            if (r_state == RESP) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed scenarios plus random accesses against an arithmetic model.
module tb_lsu_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    lsu_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_be     (mem_be),
        .o_mem_wdata  (mem_wdata),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected memory-side and response values for one request, from size/offset arithmetic
    function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] md,
                                  output bit err, output logic [31:0] ma, output logic [3:0] be,
                                  output logic [31:0] mwd, output logic [31:0] rd);
        int     nb, off, f;
        bit     legal, mis;
        longint v;
        f     = int'(f3);
        legal = we ? (f <= 2) : (f <= 2 || f == 4 || f == 5);
        nb    = 1 << (f % 4);
        off   = int'(a % 4);
        mis   = legal && ((off % nb) != 0);
`ifdef LSU_MISALIGN_TRAP_EN
        err = !legal || mis;
`else
        err = !legal;
        if (mis) off = off - (off % nb);
`endif
        ma  = a - (a % 4);
        be  = 4'hF;
        mwd = wd;
        rd  = 32'h0;
        if (legal && we) begin
            be = 4'(((1 << nb) - 1) << off);
            if (nb == 1) mwd = (wd % 256) * 32'h0101_0101;
            else if (nb == 2) mwd = (wd % 65536) * 32'h0001_0001;
        end
        if (!err && !we) begin
            v = (longint'(md) >> (8 * off)) % (longint'(1) << (8 * nb));
            if (f < 4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                v = v - (longint'(1) << (8 * nb));
            rd = 32'(v);
        end
    endfunction

    // One complete access: gd cycles of withheld grant, rv cycles before read data, same = gnt+rvalid together
    task automatic access(input string tag, input bit we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] md,
                          input int gd, input int rv, input bit same);
        bit          err;
        logic [31:0] ea, ewd, erd;
        logic [3:0]  ebe;
        model(we, f3, a, wd, md, err, ea, ebe, ewd, erd);
        chk({tag, ".ready_idle"}, req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        chk({tag, ".ready_busy"}, req_ready, 0);
        if (err) begin
            chk({tag, ".err_no_req"}, mem_req, 0);
            chk({tag, ".err_valid"}, rsp_valid, 1);
            chk({tag, ".err_flag"}, rsp_err, 1);
            chk({tag, ".err_rdata"}, rsp_rdata, 0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                chk({tag, ".req"}, mem_req, 1);
                chk({tag, ".addr"}, mem_addr, ea);
                chk({tag, ".be"}, 32'(mem_be), 32'(ebe));
                chk({tag, ".we"}, mem_we, 32'(we));
                if (we) chk({tag, ".wdata"}, mem_wdata, ewd);
                chk({tag, ".no_rsp_req"}, rsp_valid, 0);
                if (i < gd) begin
                    mem_gnt    = 1'b0;
                    mem_rvalid = 1'($urandom_range(0, 1));
                    mem_rdata  = $urandom;
                end else begin
                    mem_gnt    = 1'b1;
                    mem_rvalid = same;
                    mem_rdata  = md;
                end
                tick();
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (!we && !same) begin
                for (int i = 0; i <= rv; i++) begin
                    chk({tag, ".wait_no_req"}, mem_req, 0);
                    chk({tag, ".wait_no_rsp"}, rsp_valid, 0);
                    mem_rvalid = (i == rv);
                    mem_rdata  = (i == rv) ? md : $urandom;
                    tick();
                end
                mem_rvalid = 1'b0;
            end
            chk({tag, ".rsp_valid"}, rsp_valid, 1);
            chk({tag, ".rsp_err"}, rsp_err, 0);
            chk({tag, ".rsp_rdata"}, rsp_rdata, erd);
            chk({tag, ".rsp_no_req"}, mem_req, 0);
        end
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        tick();
        mem_rvalid = 1'b0;
        chk({tag, ".pulse_end"}, rsp_valid, 0);
        chk({tag, ".back_idle"}, req_ready, 1);
        chk({tag, ".idle_no_req"}, mem_req, 0);
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;

        tick();
        tick();
        chk("reset.ready", req_ready, 1);
        chk("reset.mem_req", mem_req, 0);
        chk("reset.rsp_valid", rsp_valid, 0);
        chk("reset.rsp_err", rsp_err, 0);
        chk("reset.mem_be", 32'(mem_be), 0);
        chk("reset.rsp_rdata", rsp_rdata, 0);
        reset      = 1'b1;
        mem_rvalid = 1'b0;
        tick();
        chk("reset.ignored_rvalid", rsp_valid, 0);

        access("lb",  1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
        access("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
        access("sh",  1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0, 3, 0, 1'b0);
        access("lw_same", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 0, 1'b1);
        access("lw_mis", 1'b0, 3'b010, 32'h0000_0042, 32'h0, 32'hCAFE_F00D, 0, 1, 1'b0);
        access("ld_bad", 1'b0, 3'b011, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 1'b0);
        access("st_bad", 1'b1, 3'b100, 32'h0000_0040, 32'h1, 32'h0, 0, 0, 1'b0);
        access("lh_hi", 1'b0, 3'b001, 32'h0000_0082, 32'h0, 32'h8001_7FFF, 1, 2, 1'b0);
        access("sb3",  1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0, 0, 1'b0);

        // Reset while waiting for read data: no response may follow the late rvalid
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        tick();
        req_valid = 1'b0;
        chk("rstwait.req", mem_req, 1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("rstwait.in_wait", mem_req, 0);
        reset = 1'b0;
        tick();
        chk("rstwait.req_low", mem_req, 0);
        chk("rstwait.no_rsp", rsp_valid, 0);
        chk("rstwait.ready", req_ready, 1);
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        chk("rstwait.late_rvalid", rsp_valid, 0);
        chk("rstwait.still_idle", req_ready, 1);

        // Reset while the request is outstanding drops mem_req
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h80;
        tick();
        req_valid = 1'b0;
        chk("rstreq.req", mem_req, 1);
        reset = 1'b0;
        tick();
        chk("rstreq.req_low", mem_req, 0);
        chk("rstreq.ready", req_ready, 1);
        reset = 1'b1; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("rstreq.no_rsp", rsp_valid, 0);
        chk("rstreq.no_req", mem_req, 0);

        for (int n = 0; n < 60; n++) begin
            access($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
